// File: rtl/vt100_fb_sched.sv
// vt100_fb_sched
//   Shares the VT100 text framebuffer between the controller CPU write path and
//   a fill/scroll engine. The engine can clear the whole screen, clear one row,
//   or scroll the screen up by one row and fill the freed last row.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     cpu_a/cpu_d/cpu_we    CPU cell write request; cpu_ready = accepted this cycle
//     cmd_valid/cmd_ready   engine command handshake
//     cmd_op/cmd_row/cmd_fill  00 clear screen, 01 scroll up, 10 clear row, 11 no-op
//     fb_ra/fb_rd/fb_q      framebuffer read port (1-cycle latency, data held)
//     fb_a/fb_d/fb_we       framebuffer write port
//     busy                  engine owns a command (cycle after accept .. DONE)
//     done                  single-cycle pulse when an engine command finishes
//
//   Configuration macro: VT100_FB_CPU_LOCK_EN
//     defined     - cpu_ready = !busy; CPU writes wait for the whole engine command.
//     not defined - cpu_ready = 1; CPU writes win arbitration and stall the engine
//                   by one cycle each.
//
//   All framebuffer outputs are registered. A write decided in cycle N appears
//   on fb_we/fb_a/fb_d in cycle N+1. Read strobes are computed from the next
//   state so fb_rd is high exactly while the FSM sits in COPY_RD, which makes
//   fb_q valid during the following COPY_WR cycle.
module vt100_fb_sched #(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cpu_a,
    input  logic [15:0] cpu_d,
    input  logic        cpu_we,
    output logic        cpu_ready,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_row,
    input  logic [15:0] cmd_fill,
    output logic [11:0] fb_ra,
    output logic        fb_rd,
    input  logic [15:0] fb_q,
    output logic [11:0] fb_a,
    output logic [15:0] fb_d,
    output logic        fb_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COPY_RD = 3'd1,
        S_COPY_WR = 3'd2,
        S_FILL    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [11:0] COLS_A        = 12'(COLS);
    localparam logic [11:0] CELLS_LAST    = 12'(COLS * ROWS - 1);
    localparam logic [11:0] COPY_LAST     = 12'(COLS * (ROWS - 1) - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'(COLS * (ROWS - 1));
    localparam logic [31:0] ROWS_U        = 32'(ROWS);

    state_t      state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic [11:0] end_q, end_d;
    logic [15:0] fill_q, fill_d;
    logic [11:0] fb_ra_q, fb_ra_d;
    logic        fb_rd_q, fb_rd_d;
    logic [11:0] fb_a_q, fb_a_d;
    logic [15:0] fb_d_q, fb_d_d;
    logic        fb_we_q, fb_we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic        cpu_grant_s;
    logic        eng_we_s;
    logic [15:0] eng_wd_s;
    logic [11:0] row_base_s;
    logic        row_ok_s;

`ifdef VT100_FB_CPU_LOCK_EN
    assign cpu_ready = ~busy_q;
`else
    assign cpu_ready = 1'b1;
`endif

    assign cpu_grant_s = cpu_we & cpu_ready;
    // Only meaningful when row_ok_s; truncation to 12 bits is harmless then.
    assign row_base_s  = 12'(cmd_row) * COLS_A;
    assign row_ok_s    = ({27'd0, cmd_row} < ROWS_U);

    assign cmd_ready = cmd_ready_q;
    assign fb_ra     = fb_ra_q;
    assign fb_rd     = fb_rd_q;
    assign fb_a      = fb_a_q;
    assign fb_d      = fb_d_q;
    assign fb_we     = fb_we_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state, engine write request and registered-output computation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        end_d    = end_q;
        fill_d   = fill_q;
        eng_we_s = 1'b0;
        eng_wd_s = fill_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    fill_d = cmd_fill;
                    case (cmd_op)
                        2'b00: begin
                            state_d = S_FILL;
                            idx_d   = 12'd0;
                            end_d   = CELLS_LAST;
                        end
                        2'b01: begin
                            state_d = S_COPY_RD;
                            idx_d   = 12'd0;
                            end_d   = COPY_LAST;
                        end
                        2'b10: begin
                            if (row_ok_s) begin
                                state_d = S_FILL;
                                idx_d   = row_base_s;
                                end_d   = row_base_s + COLS_A - 12'd1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        default: state_d = S_DONE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COPY_RD: state_d = S_COPY_WR;
            S_COPY_WR: begin
                // fb_q is held by the RAM, so a stalled copy write stays correct.
                if (!cpu_grant_s) begin
                    eng_we_s = 1'b1;
                    eng_wd_s = fb_q;
                    if (idx_q == end_q) begin
                        state_d = S_FILL;
                        idx_d   = LAST_ROW_BASE;
                        end_d   = CELLS_LAST;
                    end else begin
                        state_d = S_COPY_RD;
                        idx_d   = idx_q + 12'd1;
                    end
                end else begin
                    state_d = S_COPY_WR;
                end
            end
            S_FILL: begin
                if (!cpu_grant_s) begin
                    eng_we_s = 1'b1;
                    eng_wd_s = fill_q;
                    if (idx_q == end_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 12'd1;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // CPU has priority on the single write port.
        if (cpu_grant_s) begin
            fb_we_d = 1'b1;
            fb_a_d  = cpu_a;
            fb_d_d  = cpu_d;
        end else if (eng_we_s) begin
            fb_we_d = 1'b1;
            fb_a_d  = idx_q;
            fb_d_d  = eng_wd_s;
        end else begin
            fb_we_d = 1'b0;
            fb_a_d  = fb_a_q;
            fb_d_d  = fb_d_q;
        end

        fb_rd_d = (state_d == S_COPY_RD);
        if (state_d == S_COPY_RD) begin
            fb_ra_d = idx_d + COLS_A;
        end else begin
            fb_ra_d = fb_ra_q;
        end

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    // State, counters and registered outputs; reset aborts any command at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 12'd0;
            end_q       <= 12'd0;
            fill_q      <= 16'd0;
            fb_ra_q     <= 12'd0;
            fb_rd_q     <= 1'b0;
            fb_a_q      <= 12'd0;
            fb_d_q      <= 16'd0;
            fb_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            end_q       <= end_d;
            fill_q      <= fill_d;
            fb_ra_q     <= fb_ra_d;
            fb_rd_q     <= fb_rd_d;
            fb_a_q      <= fb_a_d;
            fb_d_q      <= fb_d_d;
            fb_we_q     <= fb_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

endmodule

// File: tb/tb_vt100_fb_sched.sv
// Self-checking bench for vt100_fb_sched: a behavioural framebuffer RAM, a
// write log, and per-scenario tasks comparing against array-level expectations.
module tb_vt100_fb_sched;
    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;
    localparam int LOGN  = 32768;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cpu_a;
    logic [15:0] cpu_d;
    logic        cpu_we;
    logic        cpu_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_row;
    logic [15:0] cmd_fill;
    logic [11:0] fb_ra;
    logic        fb_rd;
    logic [15:0] fb_q_r;
    logic [11:0] fb_a;
    logic [15:0] fb_d;
    logic        fb_we;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:4095];
    logic [15:0] pre [0:4095];
    logic [15:0] expv [0:4095];
    logic [11:0] log_a [0:LOGN-1];
    logic [15:0] log_d [0:LOGN-1];
    int          log_n = 0;
    int          done_cnt = 0;
    int          preload_mode = 0;
    logic [11:0] cq_a [$];
    logic [15:0] cq_d [$];

    always #5 clk = ~clk;

    vt100_fb_sched #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_ready(cpu_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_fill(cmd_fill),
        .fb_ra(fb_ra), .fb_rd(fb_rd), .fb_q(fb_q_r),
        .fb_a(fb_a), .fb_d(fb_d), .fb_we(fb_we),
        .busy(busy), .done(done)
    );

    // Framebuffer RAM: one write port, registered read with held data.
    always @(posedge clk) begin
        if (preload_mode == 1) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
        end else if (preload_mode == 2) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'($urandom);
        end else if (fb_we) begin
            mem[fb_a] <= fb_d;
        end
        if (fb_rd) fb_q_r <= mem[fb_ra];
    end

    // Write log and done-pulse counter.
    always @(posedge clk) begin
        if (fb_we && log_n < LOGN) begin
            log_a[log_n] <= fb_a;
            log_d[log_n] <= fb_d;
            log_n <= log_n + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic preload(input int mode);
        @(negedge clk);
        preload_mode = mode;
        @(negedge clk);
        preload_mode = 0;
        for (int i = 0; i < 4096; i++) pre[i] = mem[i];
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] row, input logic [15:0] fill);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_fill  = fill;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_row   = 5'($urandom);
        cmd_fill  = 16'($urandom);
    endtask

    // Runs until done with an optional CPU write burst; cyc counts edges from accept.
    task automatic run_op(input int budget, input int cpu_start, input int cpu_len,
                          input logic [15:0] fill, output int cyc);
        logic [15:0] d;
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            if (cyc >= cpu_start && cyc < cpu_start + cpu_len) begin
                d = 16'($urandom);
                if (d == fill) d = ~fill;
                cpu_we = 1'b1;
                cpu_a  = 12'($urandom_range(0, 4095));
                cpu_d  = d;
                cq_a.push_back(cpu_a);
                cq_d.push_back(cpu_d);
            end else begin
                cpu_we = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        cpu_we = 1'b0;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout no done within %0d cycles", budget);
        end
    endtask

    task automatic check_image(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== expv[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s %0d bad cells, first at %0d got %h want %h",
                     name, bad, first, mem[first], expv[first]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_we = 1'b0; cpu_a = 12'd0; cpu_d = 16'd0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row = 5'd0; cmd_fill = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fb_we, fb_rd, busy, done, cmd_ready, fb_a, fb_ra, fb_d} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state got we%b rd%b busy%b done%b rdy%b a%h ra%h d%h want 0000 1 0 0 0",
                     fb_we, fb_rd, busy, done, cmd_ready, fb_a, fb_ra, fb_d);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, cpu_ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL post_reset got rdy%b cpu_rdy%b busy%b want 110", cmd_ready, cpu_ready, busy);
        end
    endtask

    task automatic test_scroll();
        int cyc;
        int base;
        logic [15:0] fill;
        for (int it = 0; it < 2; it++) begin
            preload(it == 0 ? 1 : 2);
            fill = (it == 0) ? 16'h0720 : 16'($urandom);
            base = log_n;
            issue(2'b01, 5'($urandom), fill);
            run_op(5000, 0, 0, fill, cyc);
            checks++;
            if (cyc != 3921) begin
                errors++;
                $display("FAIL scroll_cycles got %0d want 3921", cyc);
            end
            @(negedge clk);
            checks++;
            if ({done, cmd_ready, busy} !== 3'b010) begin
                errors++;
                $display("FAIL scroll_after_done got done%b rdy%b busy%b want 010", done, cmd_ready, busy);
            end
            for (int i = 0; i < 4096; i++) begin
                if (i < CELLS - COLS) expv[i] = pre[i + COLS];
                else if (i < CELLS) expv[i] = fill;
                else expv[i] = pre[i];
            end
            check_image("scroll_image");
            checks++;
            if (log_n - base != CELLS) begin
                errors++;
                $display("FAIL scroll_write_count got %0d want %0d", log_n - base, CELLS);
            end
            if (it == 0) begin
                checks++;
                if ({mem[0], mem[1919], mem[1920], mem[1999]} !==
                    {16'd80, 16'd1999, 16'h0720, 16'h0720}) begin
                    errors++;
                    $display("FAIL scroll_spot got %h %h %h %h want 0050 07cf 0720 0720",
                             mem[0], mem[1919], mem[1920], mem[1999]);
                end
            end
        end
    endtask

    task automatic test_clear_row();
        int cyc;
        int base;
        int bad;
        int row;
        logic [15:0] fill;
        for (int it = 0; it < 4; it++) begin
            row  = (it == 0) ? 3 : ((it == 1) ? 0 : ((it == 2) ? 24 : $urandom_range(0, 24)));
            fill = (it == 0) ? 16'h1F41 : 16'($urandom);
            preload(2);
            base = log_n;
            issue(2'b10, 5'(row), fill);
            run_op(300, 0, 0, fill, cyc);
            checks++;
            if (cyc != 81) begin
                errors++;
                $display("FAIL row_cycles row %0d got %0d want 81", row, cyc);
            end
            @(negedge clk);
            bad = 0;
            if (log_n - base != COLS) bad++;
            for (int k = 0; k < COLS && base + k < log_n; k++)
                if (log_a[base + k] !== 12'(row * COLS + k) || log_d[base + k] !== fill) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL row_writes row %0d got %0d writes, %0d bad want %0d writes at %0d..",
                         row, log_n - base, bad, COLS, row * COLS);
            end
            for (int i = 0; i < 4096; i++)
                expv[i] = (i >= row * COLS && i < row * COLS + COLS) ? fill : pre[i];
            check_image("row_image");
        end
        // Out-of-range rows and the reserved op finish at once with no writes.
        for (int it = 0; it < 3; it++) begin
            base = log_n;
            row  = $urandom_range(25, 31);
            issue(it == 2 ? 2'b11 : 2'b10, 5'(row), 16'($urandom));
            run_op(20, 0, 0, 16'd0, cyc);
            checks++;
            if (cyc != 1) begin
                errors++;
                $display("FAIL noop_cycles op%0d row %0d got %0d want 1", it == 2 ? 3 : 2, row, cyc);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (log_n != base || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL noop_writes got %0d writes rdy%b want 0 writes rdy1", log_n - base, cmd_ready);
            end
        end
    endtask

    task automatic test_clear_screen();
        int cyc;
        int base;
        int eng;
        int ci;
        int bad;
        logic [15:0] fill;
        int nburst;
`ifdef VT100_FB_CPU_LOCK_EN
        nburst = 1;
`else
        nburst = 2;
`endif
        for (int it = 0; it < nburst; it++) begin
            fill = 16'($urandom);
            cq_a.delete();
            cq_d.delete();
            base = log_n;
            issue(2'b00, 5'($urandom), fill);
            run_op(5000, (it == 0) ? 0 : $urandom_range(100, 1500), (it == 0) ? 0 : 10, fill, cyc);
            checks++;
            if (cyc != ((it == 0) ? 2001 : 2011)) begin
                errors++;
                $display("FAIL clear_cycles got %0d want %0d", cyc, (it == 0) ? 2001 : 2011);
            end
            @(negedge clk);
            eng = 0;
            ci  = 0;
            bad = 0;
            for (int k = base; k < log_n; k++) begin
                if (log_d[k] === fill) begin
                    if (log_a[k] !== 12'(eng)) bad++;
                    eng++;
                end else begin
                    if (ci >= cq_a.size() || log_a[k] !== cq_a[ci] || log_d[k] !== cq_d[ci]) bad++;
                    ci++;
                end
            end
            checks++;
            if (eng != CELLS || ci != cq_a.size() || bad != 0) begin
                errors++;
                $display("FAIL clear_writes got eng %0d cpu %0d bad %0d want eng %0d cpu %0d bad 0",
                         eng, ci, bad, CELLS, cq_a.size());
            end
        end
    endtask

`ifdef VT100_FB_CPU_LOCK_EN
    task automatic test_lock();
        int cyc;
        int start;
        int viol;
        int hits;
        logic [11:0] a;
        logic [15:0] d;
        preload(2);
        a = 12'($urandom_range(2000, 4095));
        d = 16'($urandom);
        start = $urandom_range(50, 3000);
        issue(2'b01, 5'd0, 16'h0720);
        cyc = 1;
        viol = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            if (cyc == start) begin
                cpu_we = 1'b1; cpu_a = a; cpu_d = d;
            end
            @(negedge clk);
            cyc++;
            if (busy === 1'b1 && cpu_ready !== 1'b0) viol++;
        end
        checks++;
        if (cyc != 3921 || viol != 0) begin
            errors++;
            $display("FAIL lock_scroll got cycles %0d ready_viol %0d want 3921 0", cyc, viol);
        end
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_release got cpu_ready %b want 1", cpu_ready);
        end
        @(negedge clk);
        cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        hits = 0;
        for (int k = 0; k < log_n; k++)
            if (log_a[k] === a && log_d[k] === d) hits++;
        checks++;
        if (hits != 1 || mem[a] !== d) begin
            errors++;
            $display("FAIL lock_cpu_write got %0d writes cell %h want 1 write cell %h", hits, mem[a], d);
        end
    endtask
`endif

    task automatic test_cmd_while_busy();
        int cyc;
        int base;
        int dbase;
        int viol;
        int row;
        preload(2);
        row = $urandom_range(0, 24);
        base = log_n;
        dbase = done_cnt;
        issue(2'b10, 5'(row), 16'($urandom));
        cyc = 1;
        viol = 0;
        while (done !== 1'b1 && cyc < 300) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_row   = 5'($urandom);
            if (cmd_valid && cmd_ready !== 1'b0) viol++;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (cyc != 81 || viol != 0) begin
            errors++;
            $display("FAIL busy_cmd got cycles %0d ready_viol %0d want 81 0", cyc, viol);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (done_cnt - dbase != 1 || log_n - base != COLS) begin
            errors++;
            $display("FAIL busy_cmd_effects got %0d done %0d writes want 1 done %0d writes",
                     done_cnt - dbase, log_n - base, COLS);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int base;
        int dbase;
        preload(2);
        issue(2'b01, 5'd0, 16'h0720);
        cyc = 1;
        while (!(fb_we === 1'b1 && fb_a === 12'd500) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (fb_we !== 1'b1 || fb_a !== 12'd500) begin
            errors++;
            $display("FAIL midreset_reach got we%b a%0d want we1 a500", fb_we, fb_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_we, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_same_cycle got we%b busy%b done%b want 000", fb_we, busy, done);
        end
        base = log_n;
        dbase = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (log_n != base || done_cnt != dbase || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after got %0d writes %0d done rdy%b busy%b want 0 0 1 0",
                     log_n - base, done_cnt - dbase, cmd_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_clear_row();
        test_clear_screen();
`ifdef VT100_FB_CPU_LOCK_EN
        test_lock();
`endif
        test_cmd_while_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
